gsim_update: RTL and testbench
==============================

GSIM_UPDATE -- requirements
Module: gsim_update

Interface
REQ-001 Parameter ITER_MAX, default 64: number of full 16-unknown sweeps before completion.
REQ-002 Parameter N_UNK, default 16: unknowns per sweep.
REQ-003 clk  input  1  clock; all state updates on rising edge.
REQ-004 rst  input  1  reset, synchronous, active-high.
REQ-005 in_valid_i  input  1  operand set valid this cycle.
REQ-006 b_i  input  16  signed integer right-hand-side term for the current unknown.
REQ-007 p1_i, m1_i, p2_i, m2_i, p3_i, m3_i  input  32 each  signed Q16.16 neighbours x[i±1], x[i±2], x[i±3], driven by the solution register file.
REQ-008 out_valid_o  output  1  x_o valid this cycle.
REQ-009 x_o  output  32  signed Q16.16 updated unknown, fed back to the register-file target input.
REQ-010 idx_o  output  4  index of the unknown carried by x_o (0..N_UNK-1).
REQ-011 iter_o  output  16  completed-sweep count.
REQ-012 done_o  output  1  high once ITER_MAX sweeps have been emitted; sticky until rst.

Function
REQ-013 Compute S = (b_i<<16) + 13*(p1+m1) - 6*(p2+m2) + (p3+m3) exactly in 40-bit signed arithmetic, with no intermediate truncation.
REQ-014 Compute Q = floor(S*52429 / 2^20) using an arithmetic right shift of the exact signed product (reciprocal approximation of /20).
REQ-015 x_o = Q saturated to [0x80000000, 0x7FFFFFFF].
REQ-016 Fixed 3-stage pipeline: stage1 pair sums, stage2 weighted sum S, stage3 multiply/shift/saturate.
REQ-017 An operand set accepted at edge t appears on x_o with out_valid_o=1 after edge t+3.
REQ-018 Accept one operand set per cycle with no back-pressure; back-to-back in_valid_i gives back-to-back out_valid_o.
REQ-019 Bubbles propagate: in_valid_i=0 produces out_valid_o=0 exactly 3 cycles later.
REQ-020 x_o holds its last value when out_valid_o=0.
REQ-021 idx_o is the index of the current output; after each emitted output, idx increments, wrapping N_UNK-1 -> 0.
REQ-022 Each wrap of idx increments iter_o by 1.
REQ-023 States IDLE, RUN, DONE: IDLE->RUN on first accepted in_valid_i; RUN->DONE on the cycle the output with idx=N_UNK-1 and iter_o=ITER_MAX-1 is emitted; DONE holds until rst.
REQ-024 done_o=1 in the same cycle as that final out_valid_o.
REQ-025 In DONE, in_valid_i is ignored and in-flight pipeline entries are discarded (out_valid_o forced 0).
REQ-026 iter_o saturates at ITER_MAX and never wraps.

Reset
REQ-027 On rst, all pipeline valid bits clear, x_o=0, out_valid_o=0, idx_o=0, iter_o=0, done_o=0, and the state returns to IDLE.
REQ-028 rst dominates in_valid_i in the same cycle; operands presented during rst are dropped.
REQ-029 rst asserted mid-operation discards all in-flight entries; no out_valid_o in the cycle after rst.

Structure
REQ-030 Shared package gsim_pkg holds: coefficients 13/6/1, reciprocal 52429, shift 20, widths X_W=32, B_W=16, ACC_W=40, and the state enum.
REQ-031 Sub-module gsim_iter_ctrl holds the idx/iter counters and the IDLE/RUN/DONE FSM; the datapath stays in gsim_update.

Verification
REQ-032 b=20, all neighbours 0, one in_valid -> x_o=0x00010000, out_valid_o 3 cycles later, idx_o=0.
REQ-033 b=0, p1=m1=0x00010000, others 0 -> x_o=0x00014CCD.
REQ-034 b=-20, neighbours 0 -> x_o=0xFFFEFFFF (floor rounding check).
REQ-035 b=32767, p1=m1=p3=m3=0x7FFFFFFF, p2=m2=0x80000000 -> x_o=0x7FFFFFFF (saturation).
REQ-036 ITER_MAX=2, 40 back-to-back in_valid -> exactly 32 outputs; idx_o runs 0..15 twice; iter_o ends at 2; done_o rises with output 32; no further out_valid_o.
REQ-037 rst asserted with 2 entries in flight -> out_valid_o=0 in the following 3 cycles; idx_o=0, iter_o=0, done_o=0.

Source files
------------

// File: rtl/gsim_pkg.sv
// Shared constants, widths and state encoding for the Gauss-Seidel unknown-update block.
package gsim_pkg;

    localparam int X_W         = 32;
    localparam int B_W         = 16;
    localparam int ACC_W       = 40;
    localparam int PROD_W      = 58;
    localparam int RECIP_SHIFT = 20;
    localparam int Q_W         = PROD_W - RECIP_SHIFT;
    localparam int IDX_W       = 4;
    localparam int ITER_W      = 16;

    localparam int COEF_1 = 13;
    localparam int COEF_2 = 6;
    localparam int COEF_3 = 1;
    localparam int RECIP  = 52429;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_RUN  = 2'd1,
        ST_DONE = 2'd2
    } gsim_state_e;

    // Clamp the shifted quotient into the signed Q16.16 output range.
    function automatic logic signed [X_W-1:0] sat_x(input logic signed [Q_W-1:0] q);
        logic signed [X_W-1:0] r;
        if ((&q[Q_W-1:X_W-1]) || (~|q[Q_W-1:X_W-1]))
            r = q[X_W-1:0];
        else if (q[Q_W-1])
            r = {1'b1, {(X_W-1){1'b0}}};
        else
            r = {1'b0, {(X_W-1){1'b1}}};
        return r;
    endfunction

endpackage

// File: rtl/gsim_update_if.sv
// Operand/result bundle between the solution register file and the update pipeline.
interface gsim_update_if;
    import gsim_pkg::*;

    logic                     in_valid_i;
    logic signed [B_W-1:0]    b_i;
    logic signed [X_W-1:0]    p1_i;
    logic signed [X_W-1:0]    m1_i;
    logic signed [X_W-1:0]    p2_i;
    logic signed [X_W-1:0]    m2_i;
    logic signed [X_W-1:0]    p3_i;
    logic signed [X_W-1:0]    m3_i;
    logic                     out_valid_o;
    logic signed [X_W-1:0]    x_o;
    logic [IDX_W-1:0]         idx_o;
    logic [ITER_W-1:0]        iter_o;
    logic                     done_o;

    modport master (
        output in_valid_i, b_i, p1_i, m1_i, p2_i, m2_i, p3_i, m3_i,
        input  out_valid_o, x_o, idx_o, iter_o, done_o
    );

    modport slave (
        input  in_valid_i, b_i, p1_i, m1_i, p2_i, m2_i, p3_i, m3_i,
        output out_valid_o, x_o, idx_o, iter_o, done_o
    );

endinterface

// File: rtl/gsim_iter_ctrl.sv
// Output qualifier, unknown index / sweep counters and the run-state FSM.
// state   | meaning
// ST_IDLE | waiting for the first operand set after reset
// ST_RUN  | sweeping; each emitted output advances idx, each idx wrap advances iter
// ST_DONE | ITER_MAX sweeps emitted; outputs suppressed until rst
module gsim_iter_ctrl
    import gsim_pkg::*;
#(
    parameter int ITER_MAX = 64,
    parameter int N_UNK    = 16
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              in_valid_i,
    input  logic              pipe_valid_i,
    output logic              out_valid_o,
    output logic [IDX_W-1:0]  idx_o,
    output logic [ITER_W-1:0] iter_o,
    output logic              done_o
);

    localparam logic [IDX_W-1:0]  IDX_LAST  = IDX_W'(N_UNK - 1);
    localparam logic [ITER_W-1:0] ITER_LIM  = ITER_W'(ITER_MAX);
    localparam logic [ITER_W-1:0] ITER_LAST = ITER_W'(ITER_MAX - 1);

    gsim_state_e       state_q;
    logic              out_valid_q;
    logic [IDX_W-1:0]  idx_q, idx_d;
    logic [ITER_W-1:0] iter_q, iter_d;
    logic              done_q;
    logic              emit, last_out;

    // idx/iter advance on the edge that retires the currently displayed output.
    always_comb begin
        idx_d    = idx_q;
        iter_d   = iter_q;
        emit     = 1'b0;
        last_out = 1'b0;
        if (out_valid_q) begin
            if (idx_q == IDX_LAST) begin
                idx_d = '0;
                if (iter_q != ITER_LIM)
                    iter_d = iter_q + 1'b1;
            end else begin
                idx_d = idx_q + 1'b1;
            end
        end
        emit     = pipe_valid_i && (state_q != ST_DONE);
        last_out = emit && (idx_d == IDX_LAST) && (iter_d == ITER_LAST);
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q     <= ST_IDLE;
            out_valid_q <= 1'b0;
            idx_q       <= '0;
            iter_q      <= '0;
            done_q      <= 1'b0;
        end else begin
            out_valid_q <= emit;
            idx_q       <= idx_d;
            iter_q      <= iter_d;
            case (state_q)
                ST_IDLE: begin
                    if (in_valid_i)
                        state_q <= ST_RUN;
                end
                ST_RUN: begin
                    if (last_out) begin
                        state_q <= ST_DONE;
                        done_q  <= 1'b1;
                    end
                end
                ST_DONE: begin
                    state_q <= ST_DONE;
                end
                default: begin
                    state_q <= ST_IDLE;
                end
            endcase
        end
    end

    assign out_valid_o = out_valid_q;
    assign idx_o       = idx_q;
    assign iter_o      = iter_q;
    assign done_o      = done_q;

endmodule

// File: rtl/gsim_update.sv
// Gauss-Seidel 7-point unknown update: x = floor(S * 52429 / 2^20), saturated to Q16.16.
// Four register ranks: pair sums, weighted sum, reciprocal product, shifted/saturated output.
module gsim_update
    import gsim_pkg::*;
#(
    parameter int ITER_MAX = 64,
    parameter int N_UNK    = 16
) (
    input  logic         clk,
    input  logic         rst,
    gsim_update_if.slave bus
);

    localparam logic signed [ACC_W-1:0]  K1 = ACC_W'(COEF_1);
    localparam logic signed [ACC_W-1:0]  K2 = ACC_W'(COEF_2);
    localparam logic signed [ACC_W-1:0]  K3 = ACC_W'(COEF_3);
    localparam logic signed [PROD_W-1:0] KR = PROD_W'(RECIP);

    logic                      v1_q, v2_q, v3_q;
    logic                      done_w, out_valid_w;
    logic signed [B_W-1:0]     b1_q;
    logic signed [X_W:0]       s1_q, s2_q, s3_q;
    logic signed [X_W:0]       s1_d, s2_d, s3_d;
    logic signed [ACC_W-1:0]   acc_q, acc_d;
    logic signed [ACC_W-1:0]   b_ext, t1, t2, t3;
    logic signed [PROD_W-1:0]  prod_q, prod_d, acc_ext;
    logic signed [Q_W-1:0]     quot;
    logic signed [X_W-1:0]     x_q;

    always_comb begin
        s1_d    = {bus.p1_i[X_W-1], bus.p1_i} + {bus.m1_i[X_W-1], bus.m1_i};
        s2_d    = {bus.p2_i[X_W-1], bus.p2_i} + {bus.m2_i[X_W-1], bus.m2_i};
        s3_d    = {bus.p3_i[X_W-1], bus.p3_i} + {bus.m3_i[X_W-1], bus.m3_i};
        b_ext   = {{(ACC_W-B_W-16){b1_q[B_W-1]}}, b1_q, 16'd0};
        t1      = {{(ACC_W-X_W-1){s1_q[X_W]}}, s1_q};
        t2      = {{(ACC_W-X_W-1){s2_q[X_W]}}, s2_q};
        t3      = {{(ACC_W-X_W-1){s3_q[X_W]}}, s3_q};
        acc_d   = b_ext + t1 * K1 - t2 * K2 + t3 * K3;
        acc_ext = {{(PROD_W-ACC_W){acc_q[ACC_W-1]}}, acc_q};
        prod_d  = acc_ext * KR;
        quot    = Q_W'(prod_q >>> RECIP_SHIFT);
    end

    // Once done, both new operands and in-flight entries are discarded.
    always_ff @(posedge clk) begin
        if (rst) begin
            v1_q <= 1'b0;
            v2_q <= 1'b0;
            v3_q <= 1'b0;
            x_q  <= '0;
        end else begin
            v1_q <= bus.in_valid_i && !done_w;
            v2_q <= v1_q && !done_w;
            v3_q <= v2_q && !done_w;
            if (v3_q && !done_w)
                x_q <= sat_x(quot);
        end
    end

    always_ff @(posedge clk) begin
        b1_q   <= bus.b_i;
        s1_q   <= s1_d;
        s2_q   <= s2_d;
        s3_q   <= s3_d;
        acc_q  <= acc_d;
        prod_q <= prod_d;
    end

    gsim_iter_ctrl #(
        .ITER_MAX (ITER_MAX),
        .N_UNK    (N_UNK)
    ) u_ctrl (
        .clk          (clk),
        .rst          (rst),
        .in_valid_i   (bus.in_valid_i),
        .pipe_valid_i (v3_q),
        .out_valid_o  (out_valid_w),
        .idx_o        (bus.idx_o),
        .iter_o       (bus.iter_o),
        .done_o       (done_w)
    );

    assign bus.out_valid_o = out_valid_w;
    assign bus.done_o      = done_w;
    assign bus.x_o         = x_q;

endmodule

// File: tb/tb_gsim_update.sv
// Scoreboard bench for gsim_update: directed vectors, bubbles, sweep completion, reset abort.
module tb_gsim_update;

    localparam int ITER_MAX = 2;
    localparam int N_UNK    = 16;

    typedef struct {
        logic [31:0] x;
        logic [3:0]  idx;
        logic [15:0] iter;
        logic        last;
    } exp_t;

    logic clk = 1'b0;
    logic rst = 1'b1;
    always #5 clk = ~clk;

    gsim_update_if bus_if ();

    gsim_update #(
        .ITER_MAX (ITER_MAX),
        .N_UNK    (N_UNK)
    ) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus_if)
    );

    exp_t exp_q[$];
    int   n_vec = 0;
    int   n_err = 0;
    int   n_out = 0;
    int   m_idx = 0;
    int   m_iter = 0;
    bit   m_done = 1'b0;

    function automatic logic [31:0] model_x(input int b, input int p1, input int m1,
                                            input int p2, input int m2,
                                            input int p3, input int m3);
        longint s, pr, q;
        s  = (longint'(b) * 65536) + 13 * (longint'(p1) + longint'(m1))
             - 6 * (longint'(p2) + longint'(m2)) + (longint'(p3) + longint'(m3));
        pr = s * 52429;
        q  = pr >>> 20;
        if (q > 64'sd2147483647)
            return 32'h7FFFFFFF;
        if (q < -64'sd2147483648)
            return 32'h80000000;
        return q[31:0];
    endfunction

    task automatic drive_set(input bit v, input logic signed [15:0] b,
                             input logic signed [31:0] p1, input logic signed [31:0] m1,
                             input logic signed [31:0] p2, input logic signed [31:0] m2,
                             input logic signed [31:0] p3, input logic signed [31:0] m3);
        exp_t e;
        bus_if.in_valid_i = v;
        bus_if.b_i  = b;
        bus_if.p1_i = p1;
        bus_if.m1_i = m1;
        bus_if.p2_i = p2;
        bus_if.m2_i = m2;
        bus_if.p3_i = p3;
        bus_if.m3_i = m3;
        if (v && !rst && !m_done) begin
            e.x    = model_x(b, p1, m1, p2, m2, p3, m3);
            e.idx  = 4'(m_idx);
            e.iter = 16'(m_iter);
            e.last = (m_idx == N_UNK - 1) && (m_iter == ITER_MAX - 1);
            exp_q.push_back(e);
            if (e.last)
                m_done = 1'b1;
            if (m_idx == N_UNK - 1) begin
                m_idx  = 0;
                m_iter = m_iter + 1;
            end else begin
                m_idx = m_idx + 1;
            end
        end
    endtask

    task automatic apply_reset();
        @(negedge clk);
        rst = 1'b1;
        drive_set(1'b0, '0, '0, '0, '0, '0, '0, '0);
        repeat (2) @(negedge clk);
        rst = 1'b0;
        exp_q.delete();
        m_idx  = 0;
        m_iter = 0;
        m_done = 1'b0;
        n_out  = 0;
    endtask

    // Scoreboard: every emitted output must match the oldest outstanding expectation.
    always @(negedge clk) begin
        exp_t e;
        if (!rst && bus_if.out_valid_o === 1'b1) begin
            n_out++;
            n_vec++;
            if (exp_q.size() == 0) begin
                n_err++;
                $display("FAIL unexpected_out: x=%h idx=%0d iter=%0d, none expected",
                         bus_if.x_o, bus_if.idx_o, bus_if.iter_o);
            end else begin
                e = exp_q.pop_front();
                if (bus_if.x_o !== e.x || bus_if.idx_o !== e.idx ||
                    bus_if.iter_o !== e.iter || bus_if.done_o !== e.last) begin
                    n_err++;
                    $display("FAIL scoreboard: got x=%h idx=%0d iter=%0d done=%b, want x=%h idx=%0d iter=%0d done=%b",
                             bus_if.x_o, bus_if.idx_o, bus_if.iter_o, bus_if.done_o,
                             e.x, e.idx, e.iter, e.last);
                end
            end
        end
    end

    task automatic test_reset();
        @(negedge clk);
        rst = 1'b1;
        drive_set(1'b1, 16'sd20, '0, '0, '0, '0, '0, '0);
        @(negedge clk);
        n_vec += 5;
        if (bus_if.out_valid_o !== 1'b0) begin
            n_err++; $display("FAIL reset_out_valid: got %b want 0", bus_if.out_valid_o);
        end
        if (bus_if.x_o !== 32'h0) begin
            n_err++; $display("FAIL reset_x: got %h want 00000000", bus_if.x_o);
        end
        if (bus_if.idx_o !== 4'd0) begin
            n_err++; $display("FAIL reset_idx: got %0d want 0", bus_if.idx_o);
        end
        if (bus_if.iter_o !== 16'd0) begin
            n_err++; $display("FAIL reset_iter: got %0d want 0", bus_if.iter_o);
        end
        if (bus_if.done_o !== 1'b0) begin
            n_err++; $display("FAIL reset_done: got %b want 0", bus_if.done_o);
        end
        @(negedge clk);
        rst = 1'b0;
        drive_set(1'b0, '0, '0, '0, '0, '0, '0, '0);
        for (int k = 0; k < 5; k++) begin
            @(negedge clk);
            n_vec++;
            if (bus_if.out_valid_o !== 1'b0) begin
                n_err++; $display("FAIL reset_drop_operands: cycle %0d out_valid=%b want 0", k, bus_if.out_valid_o);
            end
        end
    endtask

    task automatic test_directed();
        logic signed [15:0] db  [4];
        logic signed [31:0] dp1 [4];
        logic signed [31:0] dp2 [4];
        logic signed [31:0] dp3 [4];
        logic [31:0]        dexp[4];
        int                 lat;
        logic [31:0]        xv;
        logic [3:0]         iv;
        int                 want_idx;
        db   = '{16'sd20, 16'sd0, -16'sd20, 16'sd32767};
        dp1  = '{32'sh0, 32'sh00010000, 32'sh0, 32'sh7FFFFFFF};
        dp2  = '{32'sh0, 32'sh0, 32'sh0, 32'sh80000000};
        dp3  = '{32'sh0, 32'sh0, 32'sh0, 32'sh7FFFFFFF};
        dexp = '{32'h00010000, 32'h00014CCD, 32'hFFFEFFFF, 32'h7FFFFFFF};
        for (int v = 0; v < 4; v++) begin
            want_idx = m_idx;
            @(negedge clk);
            drive_set(1'b1, db[v], dp1[v], dp1[v], dp2[v], dp2[v], dp3[v], dp3[v]);
            @(posedge clk);
            #1;
            drive_set(1'b0, '0, '0, '0, '0, '0, '0, '0);
            lat = 0;
            xv  = 'x;
            iv  = 'x;
            for (int k = 1; k <= 6; k++) begin
                @(posedge clk);
                #1;
                if (lat == 0 && bus_if.out_valid_o === 1'b1) begin
                    lat = k;
                    xv  = bus_if.x_o;
                    iv  = bus_if.idx_o;
                end
            end
            n_vec += 4;
            if (lat != 3) begin
                n_err++; $display("FAIL directed%0d_latency: got %0d want 3", v, lat);
            end
            if (xv !== dexp[v]) begin
                n_err++; $display("FAIL directed%0d_x: got %h want %h", v, xv, dexp[v]);
            end
            if (iv !== 4'(want_idx)) begin
                n_err++; $display("FAIL directed%0d_idx: got %0d want %0d", v, iv, want_idx);
            end
            if (bus_if.x_o !== dexp[v]) begin
                n_err++; $display("FAIL directed%0d_hold: got %h want %h", v, bus_if.x_o, dexp[v]);
            end
        end
    endtask

    task automatic test_bubbles();
        bit hist[32];
        apply_reset();
        for (int c = 0; c < 32; c++)
            hist[c] = (c < 24) ? 1'($urandom_range(0, 1)) : 1'b0;
        for (int c = 0; c < 32; c++) begin
            @(negedge clk);
            n_vec++;
            if (bus_if.out_valid_o !== ((c >= 4) ? hist[c-4] : 1'b0)) begin
                n_err++;
                $display("FAIL bubble_valid: cycle %0d got %b want %b", c, bus_if.out_valid_o,
                         (c >= 4) ? hist[c-4] : 1'b0);
            end
            drive_set(hist[c], 16'($urandom), $urandom, $urandom, $urandom,
                      $urandom, $urandom, $urandom);
        end
        repeat (4) @(negedge clk);
        n_vec++;
        if (exp_q.size() != 0) begin
            n_err++; $display("FAIL bubble_drain: %0d outstanding want 0", exp_q.size());
        end
    endtask

    task automatic test_back_to_back();
        apply_reset();
        for (int i = 0; i < 40; i++) begin
            @(negedge clk);
            drive_set(1'b1, 16'($urandom_range(0, 65535)), $urandom, $urandom,
                      32'($urandom_range(0, 200000)), $urandom, $urandom, $urandom);
        end
        @(negedge clk);
        drive_set(1'b0, '0, '0, '0, '0, '0, '0, '0);
        repeat (12) @(negedge clk);
        n_vec += 6;
        if (n_out != 32) begin
            n_err++; $display("FAIL b2b_out_count: got %0d want 32", n_out);
        end
        if (bus_if.iter_o !== 16'd2) begin
            n_err++; $display("FAIL b2b_iter_final: got %0d want 2", bus_if.iter_o);
        end
        if (bus_if.idx_o !== 4'd0) begin
            n_err++; $display("FAIL b2b_idx_final: got %0d want 0", bus_if.idx_o);
        end
        if (bus_if.done_o !== 1'b1) begin
            n_err++; $display("FAIL b2b_done_sticky: got %b want 1", bus_if.done_o);
        end
        if (bus_if.out_valid_o !== 1'b0) begin
            n_err++; $display("FAIL b2b_quiet: got out_valid %b want 0", bus_if.out_valid_o);
        end
        if (exp_q.size() != 0) begin
            n_err++; $display("FAIL b2b_drain: %0d outstanding want 0", exp_q.size());
        end
    endtask

    task automatic test_reset_midflight();
        apply_reset();
        for (int i = 0; i < 2; i++) begin
            @(negedge clk);
            drive_set(1'b1, 16'sd100, 32'sh00020000, '0, '0, '0, '0, '0);
        end
        @(negedge clk);
        rst = 1'b1;
        drive_set(1'b0, '0, '0, '0, '0, '0, '0, '0);
        @(negedge clk);
        rst = 1'b0;
        exp_q.delete();
        m_idx  = 0;
        m_iter = 0;
        m_done = 1'b0;
        for (int k = 0; k < 4; k++) begin
            n_vec++;
            if (bus_if.out_valid_o !== 1'b0) begin
                n_err++; $display("FAIL abort_valid: cycle %0d got %b want 0", k, bus_if.out_valid_o);
            end
            @(negedge clk);
        end
        n_vec += 3;
        if (bus_if.idx_o !== 4'd0) begin
            n_err++; $display("FAIL abort_idx: got %0d want 0", bus_if.idx_o);
        end
        if (bus_if.iter_o !== 16'd0) begin
            n_err++; $display("FAIL abort_iter: got %0d want 0", bus_if.iter_o);
        end
        if (bus_if.done_o !== 1'b0) begin
            n_err++; $display("FAIL abort_done: got %b want 0", bus_if.done_o);
        end
    endtask

    initial begin
        drive_set(1'b0, '0, '0, '0, '0, '0, '0, '0);
        test_reset();
        test_directed();
        test_bubbles();
        test_back_to_back();
        test_reset_midflight();
        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
